aes_stream_ctrl: RTL and testbench
==================================

# aes_stream_ctrl

Word-stream front end for the iterative AES-128 encryption core. Accepts plaintext as four 32-bit words over a valid/ready channel, assembles each 128-bit block, and drives the core's hold-high `start` / `done` protocol. Captures each ciphertext block and re-serialises it as four 32-bit words on an output valid/ready channel. Sits directly upstream and downstream of the core, which it instantiates alongside as a peer at the top level.

## Interface
Parameters:
- `N`, 128: key width; must match the core's `N`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word accepted when `s_valid && s_ready`.
- `s_data`  in  32  plaintext word; word 0 = bits [127:96].
- `s_key`  in  N  key; sampled with word 0 of each block only.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  output word consumed when `m_valid && m_ready`.
- `m_data`  out  32  ciphertext word; word 0 = bits [127:96].
- `m_last`  out  1  high with word 3.
- `core_start`  out  1  to core `start`; registered.
- `core_in`  out  128  to core `in`.
- `core_key`  out  N  to core `key`.
- `core_out`  in  128  from core `out`.
- `core_done`  in  1  from core `done`.
- `busy`  out  1  high while core is running or the output buffer is full.

## Operation
- Input side: 2-bit `in_idx` and 128-bit `in_buf`. Each accepted word is written at slot `in_idx`, then `in_idx` increments, wrapping 3→0. On the word 3 accept, `in_full` is set. `s_ready = !in_full`.
- `s_key` is latched into `in_key` on the word 0 accept.
- Control FSM states: IDLE, LAUNCH, RUN, CAPTURE.
  - IDLE→LAUNCH when `in_full && !out_full`.
    - This edge sets `core_start=1`, `core_in<=in_buf`, and `core_key<=in_key`.
  - LAUNCH→RUN on the next edge. The core loads round 0 here.
    - `in_full` clears on this edge, so filling of the next block overlaps the run.
  - RUN→CAPTURE on the edge where `core_done==1`.
    - This edge sets `out_buf<=core_out`, `out_full=1`, `out_idx=0`, `core_start=0`.
  - CAPTURE→IDLE unconditionally on the next edge.
- The core performs one discarded reload on the capture edge, because `start` is still high while its round counter is 0. This is expected. The reload is cleared when `core_start=0` is seen on the next edge.
- `core_in` and `core_key` are held stable from LAUNCH until CAPTURE.
- Output side: `m_valid = out_full`, and `m_data = out_buf` word `out_idx`. Each handshake increments `out_idx`. The handshake on word 3 clears `out_full`.
- `busy` = state != IDLE || `out_full`.
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0, `core_start`=0, `core_in`=0, `core_key`=0, `busy`=0. Also cleared: all indices, `in_full`, `out_full`, state=IDLE.

## Timing
- With last input word accepted at edge T and `m_ready` high:
  - launch edge T+1;
  - core load edge T+2;
  - `core_done` seen after T+2+Nr;
  - capture edge T+3+Nr, so `m_valid` is high after it (13 cycles for Nr=10);
  - four output words on consecutive cycles.
- Back-pressure: `out_full` blocks the next launch until word 3 drains. `in_full` then blocks further input.
- Word 3 drains on the same edge that IDLE sees `in_full`: launch occurs on the following edge, never the same edge.
- `s_valid` toggling mid-block: partial blocks are held indefinitely; no timeout.
- `core_done` outside RUN is ignored.
- `rst` mid-run: all state is cleared in one cycle. The core's own reset is driven from the same `rst`. A partially received block is discarded.

## Structure
- Package `aes_stream_pkg` holds:
  - `WORDS_PER_BLOCK=4`;
  - the FSM state enum;
  - the word-slice function that maps index to bit range.
- One sub-module is natural: `aes_word_serializer`. It contains the output buffer, `out_idx`, `m_valid`/`m_last` and the handshake. It is instantiated once.

## Test plan
- FIPS-197 vector.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required response: 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a with `m_last` on the fourth word, first `m_valid` 13 cycles after the last input accept.
- Two back-to-back blocks with `m_ready=1`.
  - Required response: second block's words accepted during the first run; both ciphertexts correct and in order.
- `m_ready=0` for 40 cycles after the first result.
  - Required response: `m_data` is held; the second block fills, then `s_ready=0`; no launch until word 3 drains; both results correct.
- `s_key` changed after word 0 and during the run.
  - Required response: ciphertext matches the key sampled at word 0.
- `rst` asserted 5 cycles into a run.
  - Required response: next cycle all outputs at reset values; a fresh FIPS block then yields the correct ciphertext.
- `s_valid` gaps of 3 idle cycles between words.
  - Required response: correct block assembly and correct ciphertext.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg
// Shared definitions for the AES-128 word-stream front end:
//   - block geometry (32-bit words, four words per 128-bit block)
//   - control FSM state encoding
//   - word-slice helpers mapping a word index to its bit range
//     (word 0 is the most significant word, bits [127:96])
package aes_stream_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

  localparam logic [1:0] LAST_WORD_IDX = 2'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } ctrl_state_e;

  // Extract word idx of a block; word 0 sits at the top of the vector.
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic [1:0]         idx);
    return blk[(BLOCK_W - WORD_W) - int'(idx) * WORD_W +: WORD_W];
  endfunction

  // Return blk with word idx replaced by word.
  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [1:0]         idx,
                                                  input logic [WORD_W-1:0]  word);
    logic [BLOCK_W-1:0] res;
    res = blk;
    res[(BLOCK_W - WORD_W) - int'(idx) * WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/aes_word_serializer.sv
// aes_word_serializer
// Holds one captured ciphertext block and replays it as four 32-bit words
// over a valid/ready channel, word 0 first.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        capture load_data into the buffer (only asserted while empty)
//   load_data   128-bit ciphertext block from the core
//   m_ready     downstream accepts the current word
//   m_valid     buffer holds an undelivered word
//   m_data      current word, selected by the internal word index
//   m_last      current word is word 3
//   full        buffer occupied; blocks the next core launch upstream
module aes_word_serializer
  import aes_stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_last,
  output logic               full
);

  logic [BLOCK_W-1:0] out_buf_q, out_buf_d;
  logic [1:0]         out_idx_q, out_idx_d;
  logic               out_full_q, out_full_d;
  logic               m_fire;

  assign m_fire = out_full_q && m_ready;

  // Next-state: a load restarts the word sequence; each handshake advances
  // one word and the handshake on the final word empties the buffer.
  always_comb begin
    out_buf_d  = out_buf_q;
    out_idx_d  = out_idx_q;
    out_full_d = out_full_q;
    if (load) begin
      out_buf_d  = load_data;
      out_idx_d  = '0;
      out_full_d = 1'b1;
    end else if (m_fire) begin
      out_idx_d = out_idx_q + 2'd1;
      if (out_idx_q == LAST_WORD_IDX) begin
        out_full_d = 1'b0;
      end
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_buf_q  <= '0;
      out_idx_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      out_buf_q  <= out_buf_d;
      out_idx_q  <= out_idx_d;
      out_full_q <= out_full_d;
    end
  end

  assign m_valid = out_full_q;
  assign m_data  = get_word(out_buf_q, out_idx_q);
  assign m_last  = out_full_q && (out_idx_q == LAST_WORD_IDX);
  assign full    = out_full_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
// Word-stream front end for the iterative AES-128 core. Assembles four
// 32-bit plaintext words into a block, drives the core's hold-high
// start/done protocol, and hands the ciphertext to aes_word_serializer.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   s_valid/s_ready/s_data plaintext word input channel (word 0 = [127:96])
//   s_key                  key, sampled with word 0 of each block
//   m_valid/m_ready/m_data ciphertext word output channel, m_last on word 3
//   core_start/in/key      registered drive to the core
//   core_out/core_done     core result and completion
//   busy                   core running or output buffer occupied
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int N = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic [N-1:0]       s_key,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_last,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_in,
  output logic [N-1:0]       core_key,
  input  logic [BLOCK_W-1:0] core_out,
  input  logic               core_done,
  output logic               busy
);

  ctrl_state_e        state_q, state_d;
  logic [1:0]         in_idx_q, in_idx_d;
  logic [BLOCK_W-1:0] in_buf_q, in_buf_d;
  logic [N-1:0]       in_key_q, in_key_d;
  logic               in_full_q, in_full_d;
  logic               core_start_q, core_start_d;
  logic [BLOCK_W-1:0] core_in_q, core_in_d;
  logic [N-1:0]       core_key_q, core_key_d;
  logic               capture;
  logic               out_full;
  logic               s_fire;

  assign s_ready = !in_full_q;
  assign s_fire  = s_valid && s_ready;

  // Next-state for input assembly and the launch/run/capture sequence.
  // in_full only clears on the LAUNCH edge, and no word is accepted while
  // it is set, so the input and FSM updates never collide. A launch looks
  // at the registered out_full, so a block drained on one edge launches
  // the next one an edge later.
  always_comb begin
    state_d      = state_q;
    in_idx_d     = in_idx_q;
    in_buf_d     = in_buf_q;
    in_key_d     = in_key_q;
    in_full_d    = in_full_q;
    core_start_d = core_start_q;
    core_in_d    = core_in_q;
    core_key_d   = core_key_q;
    capture      = 1'b0;

    if (s_fire) begin
      in_buf_d = put_word(in_buf_q, in_idx_q, s_data);
      in_idx_d = in_idx_q + 2'd1;
      if (in_idx_q == 2'd0) begin
        in_key_d = s_key;
      end
      if (in_idx_q == LAST_WORD_IDX) begin
        in_full_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (in_full_q && !out_full) begin
          state_d      = ST_LAUNCH;
          core_start_d = 1'b1;
          core_in_d    = in_buf_q;
          core_key_d   = in_key_q;
        end
      end
      ST_LAUNCH: begin
        state_d   = ST_RUN;
        in_full_d = 1'b0;
      end
      ST_RUN: begin
        // The core reloads once more on this edge since start is still
        // high; dropping start here discards that reload on the next edge.
        if (core_done) begin
          state_d      = ST_CAPTURE;
          core_start_d = 1'b0;
          capture      = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control FSM and input-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_idx_q     <= '0;
      in_buf_q     <= '0;
      in_key_q     <= '0;
      in_full_q    <= 1'b0;
      core_start_q <= 1'b0;
      core_in_q    <= '0;
      core_key_q   <= '0;
    end else begin
      state_q      <= state_d;
      in_idx_q     <= in_idx_d;
      in_buf_q     <= in_buf_d;
      in_key_q     <= in_key_d;
      in_full_q    <= in_full_d;
      core_start_q <= core_start_d;
      core_in_q    <= core_in_d;
      core_key_q   <= core_key_d;
    end
  end

  aes_word_serializer u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (core_out),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .full      (out_full)
  );

  assign core_start = core_start_q;
  assign core_in    = core_in_q;
  assign core_key   = core_key_q;
  assign busy       = (state_q != ST_IDLE) || out_full;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl
// Drives aes_stream_ctrl against a behavioural iterative AES-128 core with
// the hold-high start/done protocol (Nr = 10). Expected ciphertext words
// go into a queue when a block is sent and are popped by an output monitor.
module tb_aes_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic [127:0] s_key = '0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [31:0]  m_data;
  logic         m_last;
  logic         core_start;
  logic [127:0] core_in;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         core_done;
  logic         busy;

  int tests_run = 0;
  int failures  = 0;
  int cyc       = 0;
  int rx_count  = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_stream_ctrl #(.N(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_key      (s_key),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .core_start (core_start),
    .core_in    (core_in),
    .core_key   (core_key),
    .core_out   (core_out),
    .core_done  (core_done),
    .busy       (busy)
  );

  // Free-running clock and an edge counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES-128 reference arithmetic ----------------
  logic [7:0] sbox [0:255];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box built from the GF(2^8) inverse plus the affine transform, so no
  // hand-typed table is involved.
  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Round key r (0..10) from the cipher key, walking the schedule forward.
  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    {w0, w1, w2, w3} = key;
    rcon = 8'h01;
    for (int i = 1; i <= r; i++) begin
      t    = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
      w0   = w0 ^ t;
      w1   = w1 ^ w0;
      w2   = w2 ^ w1;
      w3   = w3 ^ w2;
      rcon = xtime(rcon);
    end
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ rk;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ key;
    for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(key, r), r == 10);
    return s;
  endfunction

  // ---------------- Behavioural iterative core ----------------
  // Loads on the first edge that sees start with the round counter at zero,
  // runs ten rounds, raises done for one cycle, and aborts whenever start
  // drops.
  logic [127:0] c_state = '0;
  logic [127:0] c_key   = '0;
  int           c_round = 0;
  logic         c_done  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      c_round <= 0;
      c_done  <= 1'b0;
      c_state <= '0;
    end else if (!core_start) begin
      c_round <= 0;
      c_done  <= 1'b0;
    end else if (c_round == 0) begin
      c_state <= core_in ^ core_key;
      c_key   <= core_key;
      c_round <= 1;
      c_done  <= 1'b0;
    end else begin
      c_state <= aes_round(c_state, round_key(c_key, c_round), c_round == 10);
      if (c_round == 10) begin
        c_round <= 0;
        c_done  <= 1'b1;
      end else begin
        c_round <= c_round + 1;
      end
    end
  end

  assign core_out  = c_state;
  assign core_done = c_done;

  // Output monitor: every word about to be handshaken is compared with the
  // head of the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output: got data=%h last=%b, queue empty", m_data, m_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_data !== mon_e.data || m_last !== mon_e.last) begin
          failures++;
          $display("[TB] FAIL output_word: got data=%h last=%b, expected data=%h last=%b",
                   m_data, m_last, mon_e.data, mon_e.last);
        end
      end
      rx_count++;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- Stimulus helpers ----------------
  // Queue the four expected words of a ciphertext block.
  task automatic push_block(input logic [127:0] ct);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.data = ct[127-32*i -: 32];
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  // Present one word after gap idle cycles; returns one cycle after the
  // accepting edge (posedge + 1).
  task automatic send_word(input logic [31:0] w, input logic [127:0] k, input int gap,
                           output bit ok);
    int n;
    ok = 1'b1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    s_key   = k;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n >= 500) begin
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] k0,
                            input logic [127:0] krest, input int gap, output bit ok);
    bit w_ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(pt[127-32*i -: 32], (i == 0) ? k0 : krest, gap, w_ok);
      ok = ok & w_ok;
    end
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 400) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if ({s_ready, m_valid, m_last, core_start, busy} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got s_ready,m_valid,m_last,core_start,busy=%b, expected 10000",
               {s_ready, m_valid, m_last, core_start, busy});
    end
    tests_run++;
    if (m_data !== 32'h0 || core_in !== 128'h0 || core_key !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got m_data=%h core_in=%h core_key=%h, expected all zero",
               m_data, core_in, core_key);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fips;
    bit ok;
    int t_last, n;
    m_ready = 1'b1;
    push_block(FIPS_CT);
    send_block(FIPS_PT, FIPS_KEY, FIPS_KEY, 0, ok);
    t_last = cyc;
    tests_run++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL fips_input: got input stalled, expected all words accepted");
    end
    n = 0;
    while (m_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (cyc - t_last != 13) begin
      failures++;
      $display("[TB] FAIL fips_latency: got %0d cycles, expected 13", cyc - t_last);
    end
    wait_drain(ok);
    tests_run++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL fips_drain: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok_a, ok_b, ok;
    int rx0;
    logic [127:0] pt_a, pt_b, key_a, key_b;
    pt_a  = {$urandom, $urandom, $urandom, $urandom};
    pt_b  = {$urandom, $urandom, $urandom, $urandom};
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b1;
    rx0 = rx_count;
    push_block(aes_encrypt(pt_a, key_a));
    push_block(aes_encrypt(pt_b, key_b));
    send_block(pt_a, key_a, key_a, 0, ok_a);
    send_block(pt_b, key_b, key_b, 0, ok_b);
    tests_run++;
    if (!(ok_a && ok_b) || rx_count != rx0) begin
      failures++;
      $display("[TB] FAIL b2b_overlap: got inputs_ok=%b words_out=%0d, expected 1 and 0 before first result",
               ok_a && ok_b, rx_count - rx0);
    end
    wait_drain(ok);
    tests_run++;
    if (!ok || rx_count - rx0 != 8) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got %0d words, expected 8", rx_count - rx0);
    end
  endtask

  task automatic test_backpressure;
    bit ok_a, ok_b, ok;
    int n, bad;
    logic [31:0]  held;
    logic [127:0] pt_a, pt_b, key;
    pt_a = {$urandom, $urandom, $urandom, $urandom};
    pt_b = {$urandom, $urandom, $urandom, $urandom};
    key  = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b0;
    push_block(aes_encrypt(pt_a, key));
    push_block(aes_encrypt(pt_b, key));
    send_block(pt_a, key, key, 0, ok_a);
    send_block(pt_b, key, key, 0, ok_b);
    n = 0;
    while (m_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || !(ok_a && ok_b)) begin
      failures++;
      $display("[TB] FAIL bp_full: got m_valid=%b s_ready=%b busy=%b, expected 1 0 1",
               m_valid, s_ready, busy);
    end
    held = m_data;
    bad  = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_data !== held || core_start !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL bp_hold: got %0d unstable cycles, expected 0", bad);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    n = 0;
    while (!(m_valid === 1'b1 && m_last === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (core_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_no_same_edge_launch: got core_start=%b, expected 0", core_start);
    end
    @(posedge clk); #1;
    tests_run++;
    if (core_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_launch: got core_start=%b, expected 1", core_start);
    end
    wait_drain(ok);
    tests_run++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL bp_drain: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_key_change;
    bit ok_in, ok;
    logic [127:0] pt, k1, k2, k3;
    pt = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    k3 = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b1;
    push_block(aes_encrypt(pt, k1));
    send_block(pt, k1, k2, 0, ok_in);
    s_key = k3;
    wait_drain(ok);
    tests_run++;
    if (!(ok && ok_in)) begin
      failures++;
      $display("[TB] FAIL key_change_drain: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_gaps;
    bit ok_in, ok;
    logic [127:0] pt, key;
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b1;
    push_block(aes_encrypt(pt, key));
    send_block(pt, key, key, 3, ok_in);
    wait_drain(ok);
    tests_run++;
    if (!(ok && ok_in)) begin
      failures++;
      $display("[TB] FAIL gaps_drain: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run;
    bit ok_in, ok_w, ok;
    int t_last, n;
    logic [127:0] pt, key;
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b1;
    send_block(pt, key, key, 0, ok_in);
    t_last = cyc;
    // Two words of a following block are left half-assembled.
    send_word(32'hdeadbeef, key, 0, ok_w);
    send_word(32'hcafef00d, key, 0, ok_w);
    n = 0;
    while (cyc < t_last + 7 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({s_ready, m_valid, m_last, core_start, busy} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL midrun_reset_flags: got s_ready,m_valid,m_last,core_start,busy=%b, expected 10000",
               {s_ready, m_valid, m_last, core_start, busy});
    end
    tests_run++;
    if (m_data !== 32'h0 || core_in !== 128'h0 || core_key !== 128'h0) begin
      failures++;
      $display("[TB] FAIL midrun_reset_data: got m_data=%h core_in=%h core_key=%h, expected all zero",
               m_data, core_in, core_key);
    end
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    push_block(FIPS_CT);
    send_block(FIPS_PT, FIPS_KEY, FIPS_KEY, 0, ok_in);
    wait_drain(ok);
    tests_run++;
    if (!(ok && ok_in)) begin
      failures++;
      $display("[TB] FAIL midrun_recovery: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_key_change();
    test_gaps();
    test_reset_mid_run();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
